// File: rtl/inst_mem_fetch.sv
// Word-organised instruction memory for the fetch stage: NOP fill after reset,
// run-time program-load port and a registered, back-pressurable fetch handshake.
module inst_mem_fetch #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          init_done,
  input  logic          fetch_req_valid,
  output logic          fetch_req_ready,
  input  logic [31:0]   PC,
  output logic          fetch_rsp_valid,
  input  logic          fetch_rsp_ready,
  output logic [31:0]   Instruction_Code,
  output logic [1:0]    fetch_fault,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] fill_cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic          accept;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic [31:0]   rd_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INIT;
      fill_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    case (state_q)
      S_INIT: begin
        mem_we    = !reset;
        mem_waddr = fill_cnt;
        mem_wdata = NOP_WORD;
        if (fill_cnt == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_we = !reset && load_en;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign init_done = (state_q == S_RUN);

  // Array has no reset; INIT overwrites every word before fetches are allowed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign fetch_req_ready = (state_q == S_RUN) && (!fetch_rsp_valid || fetch_rsp_ready);
  assign accept          = fetch_req_valid && fetch_req_ready;

  // Once PC >= BASE_ADDR the subtraction cannot wrap, so comparing the offset
  // against the span is equivalent to a full 32-bit upper-bound check.
  assign offset       = PC - BASE_ADDR;
  assign word_idx     = offset[AW+1:2];
  assign misaligned   = (PC[1:0] != 2'b00);
  assign out_of_range = (PC < BASE_ADDR) || (offset >= SPAN_BYTES);
  assign rd_word      = mem[word_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_rsp_valid  <= 1'b0;
      Instruction_Code <= NOP_WORD;
      fetch_fault      <= 2'b00;
    end else if (accept) begin
      fetch_rsp_valid  <= 1'b1;
      fetch_fault      <= {out_of_range, misaligned};
      Instruction_Code <= (out_of_range || misaligned) ? NOP_WORD : rd_word;
    end else if (fetch_rsp_ready) begin
      fetch_rsp_valid <= 1'b0;
    end
  end

endmodule
